// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU datapath back end: default widths,
// the product accumulator state encoding and a reference saturating add.
package alu_pkg;

  localparam int DEF_PROD_W = 8;
  localparam int DEF_ACC_W  = 12;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_ACC_W-1:0] sum;
    logic                 ovf;
  } sat_res_t;

  // Saturating add at the default widths: the carry out of the top bit
  // clamps the sum to all-ones and raises ovf.
  function automatic sat_res_t sat_add(input logic [DEF_ACC_W-1:0]  a,
                                       input logic [DEF_PROD_W-1:0] b);
    logic [DEF_ACC_W:0] wide;
    sat_res_t           res;
    wide    = {1'b0, a} + (DEF_ACC_W + 1)'(b);
    res.ovf = wide[DEF_ACC_W];
    res.sum = wide[DEF_ACC_W] ? '1 : wide[DEF_ACC_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/prod_accum_sat_adder.sv
// Combinational saturating adder: ACC_W-bit accumulator plus an unsigned
// PROD_W-bit addend, clamped to all-ones on carry out.
module sat_adder #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] wide;

  // Add one bit wider than the accumulator so the carry is visible.
  always_comb begin
    wide = {1'b0, a} + (ACC_W + 1)'(b);
    ovf  = wide[ACC_W];
    sum  = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/prod_accum.sv
// Multiply-accumulate back end: sums a burst of multiplier products and
// presents one registered result per burst.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is combinational (low while a result is held and not
// being drained, and low during clr); out_valid is registered and the result
// fields stay stable until out_ready is seen or clr discards the result.
module prod_accum
  import alu_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_pro,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nx;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_beat;
  logic [CNT_W-1:0] cnt_beat;
  logic             ovf_beat;
  logic             accept;
  logic             fresh;
  logic             burst_end;

  sat_adder #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) u_add (
    .a  (acc),
    .b  (in_pro),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  assign in_ready  = ~clr & ((state != HOLD) | out_ready);
  assign accept    = in_valid & in_ready;
  // A beat seen outside ACC (IDLE, or HOLD while draining) opens a new burst.
  assign fresh     = (state != ACC);
  assign out_valid = (state == HOLD);

  // Values the accumulator takes if the presented beat is accepted.
  always_comb begin
    acc_beat  = add_sum;
    cnt_beat  = cnt + CNT_W'(1);
    ovf_beat  = ovf | add_ovf;
    if (fresh) begin
      acc_beat = ACC_W'(in_pro);
      cnt_beat = CNT_W'(1);
      ovf_beat = 1'b0;
    end
    // Hitting the count limit forces the end regardless of in_last.
    burst_end = in_last | (cnt_beat == CNT_MAX);
  end

  // Next-state logic; clr overrides everything else.
  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) state_nx = burst_end ? HOLD : ACC;
        end
        HOLD: begin
          if (accept)         state_nx = burst_end ? HOLD : ACC;
          else if (out_ready) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Running sum, beat count and sticky overflow of the burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_beat;
      cnt <= cnt_beat;
      ovf <= ovf_beat;
    end
  end

  // Result registers load only when the ending beat moves the FSM into HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (!clr && accept && burst_end) begin
      out_sum   <= acc_beat;
      out_count <= cnt_beat;
      out_ovf   <= ovf_beat;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: a default-width instance for most scenarios and a
// 10-bit accumulator instance for saturation. A behavioural model pushes
// expected results when beats are accepted; monitors pop on output transfers.
module tb_prod_accum;

  logic       clk;
  logic       rst_n;

  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pro;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [11:0] out_sum;
  logic [3:0] out_count;
  logic       out_ovf;

  logic       clr1;
  logic       in_valid1;
  logic       in_ready1;
  logic [7:0] in_pro1;
  logic       in_last1;
  logic       out_valid1;
  logic       out_ready1;
  logic [9:0] out_sum1;
  logic [3:0] out_count1;
  logic       out_ovf1;

  int checks;
  int failures;

  // {ovf, count[3:0], sum[11:0]}
  logic [16:0] exp_q[$];
  logic [16:0] exp1_q[$];

  int m_sum, m_cnt;
  bit m_ovf;
  int m1_sum, m1_cnt;
  bit m1_ovf;

  prod_accum u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pro   (in_pro),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  prod_accum #(.ACC_W(10)) u_dut10 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr1),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .in_pro   (in_pro1),
    .in_last  (in_last1),
    .out_valid(out_valid1),
    .out_ready(out_ready1),
    .out_sum  (out_sum1),
    .out_count(out_count1),
    .out_ovf  (out_ovf1)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor for the default instance.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && out_valid && out_ready && !clr) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected: got sum=%0d count=%0d ovf=%0d, required none",
                 out_sum, out_count, out_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({out_ovf, out_count, out_sum} !== e) begin
          failures++;
          $display("FAIL result: got sum=%0d count=%0d ovf=%0d, required sum=%0d count=%0d ovf=%0d",
                   out_sum, out_count, out_ovf, e[11:0], e[15:12], e[16]);
        end
      end
    end
  end

  // Scoreboard monitor for the 10-bit instance.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && out_valid1 && out_ready1 && !clr1) begin
      checks++;
      if (exp1_q.size() == 0) begin
        failures++;
        $display("FAIL result10_unexpected: got sum=%0d count=%0d ovf=%0d, required none",
                 out_sum1, out_count1, out_ovf1);
      end else begin
        e = exp1_q.pop_front();
        if ({out_ovf1, out_count1, 2'b00, out_sum1} !== e) begin
          failures++;
          $display("FAIL result10: got sum=%0d count=%0d ovf=%0d, required sum=%0d count=%0d ovf=%0d",
                   out_sum1, out_count1, out_ovf1, e[11:0], e[15:12], e[16]);
        end
      end
    end
  end

  // Behavioural model of one accepted beat (12-bit accumulator).
  task automatic model_accept(input int pro, input bit last);
    if (m_cnt == 0) begin
      m_sum = pro;
      m_ovf = 1'b0;
    end else begin
      m_sum = m_sum + pro;
      if (m_sum > 4095) begin
        m_sum = 4095;
        m_ovf = 1'b1;
      end
    end
    m_cnt++;
    if (last || m_cnt == 15) begin
      exp_q.push_back({m_ovf, m_cnt[3:0], m_sum[11:0]});
      m_cnt = 0;
    end
  endtask

  // Behavioural model of one accepted beat (10-bit accumulator).
  task automatic model1_accept(input int pro, input bit last);
    if (m1_cnt == 0) begin
      m1_sum = pro;
      m1_ovf = 1'b0;
    end else begin
      m1_sum = m1_sum + pro;
      if (m1_sum > 1023) begin
        m1_sum = 1023;
        m1_ovf = 1'b1;
      end
    end
    m1_cnt++;
    if (last || m1_cnt == 15) begin
      exp1_q.push_back({m1_ovf, m1_cnt[3:0], m1_sum[11:0]});
      m1_cnt = 0;
    end
  endtask

  // Drive one beat on the default instance and wait (bounded) for acceptance.
  task automatic send_beat(input int pro, input bit last);
    bit ok;
    bit rdy;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_pro   = pro[7:0];
    in_last  = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ok) begin
      model_accept(pro, last);
    end else begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: got no in_ready for pro=%0d, required accept within 50 cycles", pro);
    end
  endtask

  // Drive one beat on the 10-bit instance and wait (bounded) for acceptance.
  task automatic send_beat1(input int pro, input bit last);
    bit ok;
    bit rdy;
    ok        = 1'b0;
    in_valid1 = 1'b1;
    in_pro1   = pro[7:0];
    in_last1  = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      rdy = in_ready1;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    in_valid1 = 1'b0;
    in_last1  = 1'b0;
    if (ok) begin
      model1_accept(pro, last);
    end else begin
      checks++;
      failures++;
      $display("FAIL beat10_timeout: got no in_ready for pro=%0d, required accept within 50 cycles", pro);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b0; in_valid = 1'b0; in_pro = '0; in_last = 1'b0; out_ready = 1'b1;
    clr1 = 1'b0; in_valid1 = 1'b0; in_pro1 = '0; in_last1 = 1'b0; out_ready1 = 1'b1;
    m_cnt = 0; m1_cnt = 0; m_sum = 0; m1_sum = 0; m_ovf = 0; m1_ovf = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b, required 0", out_valid); end
    checks++;
    if (out_sum !== 12'd0) begin failures++; $display("FAIL reset_sum: got %0d, required 0", out_sum); end
    checks++;
    if (out_count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d, required 0", out_count); end
    checks++;
    if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %0b, required 0", out_ovf); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b, required 1", in_ready); end
    checks++;
    if (out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_valid10: got %0b, required 0", out_valid1); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_beat(225, 0);
    send_beat(225, 0);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %0b, required 0", out_valid); end
    send_beat(225, 1);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: got out_valid=%0b, required 1", out_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drop: got out_valid=%0b, required 0", out_valid); end
  endtask

  task automatic test_saturate();
    out_ready1 = 1'b1;
    for (int i = 0; i < 5; i++) send_beat1(225, i == 4);
    @(posedge clk);
    #1;
    // Saturated sum plus zero beats must keep all-ones and the sticky flag.
    for (int i = 0; i < 5; i++) send_beat1(225, 1'b0);
    send_beat1(0, 1'b1);
    @(posedge clk);
    #1;
    // A fresh burst starts with the flag cleared.
    send_beat1(255, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_count_limit();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) send_beat(1, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL limit_end: got out_valid=%0b, required 1", out_valid); end
    send_beat(1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL limit_next_burst: got out_valid=%0b, required 0", out_valid); end
    send_beat(1, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(10 + i, 1'b1);
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %0b, required 1", out_valid); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(49, 1'b1);
    in_valid = 1'b1;
    in_pro   = 8'd6;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready: got %0b, required 0", in_ready); end
      checks++;
      if (out_sum !== 12'd49 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold: got sum=%0d valid=%0b, required sum=49 valid=1", out_sum, out_valid);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got in_ready=%0b, required 1", in_ready); end
    @(posedge clk);
    #1;
    model_accept(6, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_second: got out_valid=%0b, required 1", out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    send_beat(100, 1'b0);
    send_beat(50, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_pro   = 8'd99;
    in_last  = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_ready: got %0b, required 0", in_ready); end
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_cnt    = 0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_no_result: got out_valid=%0b, required 0", out_valid); end
    send_beat(7, 1'b1);
    @(posedge clk);
    #1;
    // Held result discarded by clr.
    out_ready = 1'b0;
    send_beat(9, 1'b1);
    void'(exp_q.pop_back());
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL abort_hold: got out_valid=%0b, required 1", out_valid); end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_hold_drop: got out_valid=%0b, required 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    send_beat(10, 1'b0);
    send_beat(20, 1'b0);
    send_beat(30, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    m_cnt  = 0;
    m1_cnt = 0;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 12'd0 || out_count !== 4'd0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_outputs: got valid=%0b sum=%0d count=%0d ovf=%0b, required all 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready: got %0b, required 1", in_ready); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(5, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_beat($urandom_range(0, 255), ($urandom_range(0, 3) == 0) || (i == 39));
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_saturate();
    test_count_limit();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_random();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp1_q.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
    end
    checks++;
    if (exp1_q.size() != 0) begin
      failures++;
      $display("FAIL drain10: got %0d results outstanding, required 0", exp1_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream consumer of the 4-bit array multiplier's 8-bit product in the 4-bit ALU datapath.
- Accumulates a burst of products into a wide sum: a multiply-accumulate back end.
- Presents one registered result per burst on a valid/ready output interface.
- Upstream side is valid/ready; a burst ends on an in_last beat or on a beat-count limit.

Parameters:
- PROD_W, 8: product width; matches the multiplier output.
- ACC_W, 12: accumulator and result width. Must be >= PROD_W.
- CNT_W, 4: beat-counter width. Maximum burst length is 2^CNT_W-1 beats.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort; discards any partial or held result.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_pro  in  PROD_W  unsigned product from the multiplier.
- in_last  in  1  final beat of the burst.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  accumulated sum, saturating.
- out_count  out  CNT_W  number of beats in the burst.
- out_ovf  out  1  sticky flag: saturation occurred during this burst.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Internal accumulator and counter cleared.
- Beat accept rule: a beat is accepted when in_valid & in_ready at a rising edge.
- in_ready is combinational: in_ready = (state!=HOLD) | out_ready, and is forced to 0 when clr=1.
- States:
  - IDLE: waiting for the first beat. On accept:
    - acc=in_pro zero-extended, cnt=1, ovf=0.
    - Go to HOLD if the burst ends on this beat, else go to ACC.
  - ACC: on accept:
    - Compute acc+in_pro at ACC_W+1 bits.
    - If the carry-out is set: acc=all-ones and ovf=1. Otherwise acc=the sum.
    - cnt=cnt+1.
    - Go to HOLD if the burst ends on this beat.
    - With no accept, hold all state.
  - HOLD: out_valid=1; out_sum/out_count/out_ovf driven from registers and held stable.
    - out_ready=1 with no accept: go to IDLE; out_valid=0 next cycle.
    - out_ready=1 with accept in the same cycle: the result drains and the new beat starts a fresh burst (IDLE semantics). Next state is ACC, or HOLD if that beat also ends its burst.
- Burst end condition: in_last=1, or the accepted beat makes cnt equal to 2^CNT_W-1. The count-limit case is a forced end; in_last is ignored for that beat.
- Latency: out_valid asserts the cycle after the ending beat is accepted.
- Throughput: one beat per cycle. A 1-beat burst can issue back-to-back when out_ready is held high.
- Output registers load on the transition into HOLD only. They are not combinational from the accumulator.
- Saturation: once ovf=1, the sum stays all-ones for the rest of the burst. Adding zero never clears it.
- clr=1 has the highest priority after reset:
  - Next state=IDLE, out_valid=0, acc/cnt/ovf cleared.
  - The beat presented that cycle is not accepted.
- in_pro=0 beats are legal; they count toward out_count.
- A beat-count of 0 is impossible; every result has out_count>=1.

Decomposition:
- Shared package alu_pkg holds:
  - PROD_W and ACC_W default constants.
  - State encoding enum: IDLE=2'd0, ACC=2'd1, HOLD=2'd2.
  - Function sat_add (ACC_W-bit saturating add, returns sum and overflow bit).
- Sub-module: sat_adder (combinational ACC_W-bit saturating adder, PROD_W-bit addend) is natural.
- FSM, counter and output registers stay in prod_accum.

Test Plan:
- Three beats 225,225,225 with in_last on the third, out_ready=1:
  - out_valid one cycle after beat 3, out_sum=675, out_count=3, out_ovf=0.
  - out_valid drops the following cycle.
- ACC_W=10 override, five beats of 225, last on beat 5:
  - out_sum=1023, out_ovf=1, out_count=5.
  - ovf sets on beat 5 (sum 1125).
- Fifteen beats of 1 with in_last never asserted:
  - forced end after beat 15, out_sum=15, out_count=15.
  - Beat 16 becomes the first beat of the next burst.
- Backpressure: result 49 (one beat, last) held with out_ready=0 for 4 cycles while in_valid=1:
  - in_ready=0 and out_sum stays 49.
  - Raise out_ready together with beat 6 (last): 49 drains, next result 6 with count 1 appears the following cycle.
- Abort: clr pulse after two beats (100,50), then beat 7 with last:
  - result out_sum=7, out_count=1.
  - clr during HOLD drops out_valid next cycle.
- Asynchronous reset: drop rst_n mid-burst between clock edges:
  - outputs go to 0 immediately and in_ready=1.
  - The first beat after release starts a new burst.
